// File: rtl/ntt_stream_ctrl_pkg.sv
// Shared definitions for the NTT stream controller: core state encoding and the
// lane bit-reversal helper (also used by the twiddle ROM tooling).
package ntt_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = v[5'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_stream_ctrl_if.sv
// Coefficient streams of the NTT controller: valid/ready input and output.
// The controller is the slave; the producer/consumer side is the master.
interface ntt_stream_ctrl_if #(
    parameter int N = 17
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         out_inv;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_inv
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, out_last, out_inv
    );
endinterface

// File: rtl/ntt_stream_ctrl_frame_buffer.sv
// D x N coefficient frame: one indexed write lane, a whole-frame parallel load,
// the whole frame as a flat vector, and one mux-selected indexed read lane.
module stream_frame_buffer #(
    parameter int N = 17,
    parameter int D = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [$clog2(D)-1:0] widx_i,
    input  logic [N-1:0]         wdata_i,
    input  logic                 ld_i,
    input  logic [D*N-1:0]       ld_data_i,
    input  logic [$clog2(D)-1:0] ridx_i,
    output logic [D*N-1:0]       all_o,
    output logic [N-1:0]         rdata_o
);
    logic [D-1:0][N-1:0] mem_q;

    // A parallel load takes priority; callers never assert both at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       mem_q <= '0;
        else if (ld_i) mem_q <= ld_data_i;
        else if (we_i) mem_q[widx_i] <= wdata_i;
    end

    assign all_o   = mem_q;
    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/ntt_stream_ctrl.sv
// Stream front/back end for the parallel NTT unit: loads a D-lane frame, launches
// the unit, captures the result and drains it, with separate in/out buffers.
module ntt_stream_ctrl
    import ntt_stream_ctrl_pkg::*;
#(
    parameter int N      = 17,
    parameter int D      = 32,
    parameter int PU_LAT = $clog2(D),
    parameter int BITREV = 0
) (
    input  logic             clk,
    input  logic             rst,
    ntt_stream_ctrl_if.slave s,
    output logic [D*N-1:0]   pu_a_o,
    output logic             pu_inv_o,
    output logic             pu_start_o,
    input  logic [D*N-1:0]   pu_an_i,
    output logic             busy_o
);
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(PU_LAT + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  wr_idx_q, rd_idx_q, rd_sel;
    logic           in_full_q, out_full_q, frame_inv_q, out_inv_q, pu_inv_q;
    logic [D*N-1:0] pu_a_q, ibuf_all;
    logic [N-1:0]   obuf_rd;
    logic           launch, capture, in_hs, out_hs;
    logic [N-1:0]   unused_ibuf_rd;
    logic [D*N-1:0] unused_obuf_all;

    assign in_hs  = s.in_valid & ~in_full_q;
    assign out_hs = out_full_q & s.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_full_q && !out_full_q) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    launch  = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PU_LAT - 1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                capture = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load side; the index wraps to 0 after the last beat since D is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q    <= '0;
            in_full_q   <= 1'b0;
            frame_inv_q <= 1'b0;
        end else if (capture) begin
            wr_idx_q  <= '0;
            in_full_q <= 1'b0;
        end else if (in_hs) begin
            wr_idx_q <= wr_idx_q + 1'b1;
            if (wr_idx_q == '0)          frame_inv_q <= s.in_inv;
            if (wr_idx_q == AW'(D - 1))  in_full_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_a_q   <= '0;
            pu_inv_q <= 1'b0;
        end else if (launch) begin
            pu_a_q   <= ibuf_all;
            pu_inv_q <= frame_inv_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_q   <= '0;
            out_full_q <= 1'b0;
            out_inv_q  <= 1'b0;
        end else if (capture) begin
            out_full_q <= 1'b1;
            out_inv_q  <= pu_inv_q;
        end else if (out_hs) begin
            if (rd_idx_q == AW'(D - 1)) begin
                out_full_q <= 1'b0;
                rd_idx_q   <= '0;
            end else begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
        end
    end

    assign rd_sel = (BITREV != 0) ? AW'(bitrev(32'(rd_idx_q), AW)) : rd_idx_q;

    stream_frame_buffer #(.N(N), .D(D)) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (in_hs),
        .widx_i   (wr_idx_q),
        .wdata_i  (s.in_data),
        .ld_i     (1'b0),
        .ld_data_i('0),
        .ridx_i   ('0),
        .all_o    (ibuf_all),
        .rdata_o  (unused_ibuf_rd)
    );

    stream_frame_buffer #(.N(N), .D(D)) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (1'b0),
        .widx_i   ('0),
        .wdata_i  ('0),
        .ld_i     (capture),
        .ld_data_i(pu_an_i),
        .ridx_i   (rd_sel),
        .all_o    (unused_obuf_all),
        .rdata_o  (obuf_rd)
    );

    assign s.in_ready  = ~in_full_q;
    assign s.out_valid = out_full_q;
    assign s.out_data  = obuf_rd;
    assign s.out_last  = out_full_q & (rd_idx_q == AW'(D - 1));
    assign s.out_inv   = out_inv_q;
    assign pu_a_o      = pu_a_q;
    assign pu_inv_o    = pu_inv_q;
    assign pu_start_o  = (state_q == ST_RUN) && (cnt_q == '0);
    assign busy_o      = in_full_q | (wr_idx_q != '0) | (state_q != ST_IDLE) | out_full_q;
endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Random/directed bench: two controllers (natural and bit-reversed order) share
// one stimulus and are checked against a frame-level model with a PU model.
module tb_ntt_stream_ctrl;
    localparam int N = 17, D = 4, PU_LAT = 2, LG = 2;

    typedef struct packed {
        logic                inv;
        logic [D-1:0][N-1:0] a;
    } fr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_stream_ctrl_if #(.N(N)) if0 ();
    ntt_stream_ctrl_if #(.N(N)) if1 ();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_data   = if0.in_data;
    assign if1.in_inv    = if0.in_inv;
    assign if1.out_ready = if0.out_ready;

    logic [D*N-1:0] pu_a0, pu_a1;
    logic           pu_inv0, pu_inv1, pu_start0, pu_start1, busy0, busy1;
    logic [1:0][D*N-1:0] pu_an, pu_st1;

    ntt_stream_ctrl #(.N(N), .D(D), .PU_LAT(PU_LAT), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .s(if0), .pu_a_o(pu_a0), .pu_inv_o(pu_inv0),
        .pu_start_o(pu_start0), .pu_an_i(pu_an[0]), .busy_o(busy0));

    ntt_stream_ctrl #(.N(N), .D(D), .PU_LAT(PU_LAT), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .s(if1), .pu_a_o(pu_a1), .pu_inv_o(pu_inv1),
        .pu_start_o(pu_start1), .pu_an_i(pu_an[1]), .busy_o(busy1));

    logic [1:0] o_in_ready, o_out_valid, o_out_last, o_out_inv, o_pu_start, o_pu_inv, o_busy;
    logic [1:0][D*N-1:0] o_pu_a;
    logic [1:0][N-1:0]   o_out_data;
    assign o_in_ready  = {if1.in_ready, if0.in_ready};
    assign o_out_valid = {if1.out_valid, if0.out_valid};
    assign o_out_last  = {if1.out_last, if0.out_last};
    assign o_out_inv   = {if1.out_inv, if0.out_inv};
    assign o_out_data  = {if1.out_data, if0.out_data};
    assign o_pu_start  = {pu_start1, pu_start0};
    assign o_pu_inv    = {pu_inv1, pu_inv0};
    assign o_busy      = {busy1, busy0};
    assign o_pu_a      = {pu_a1, pu_a0};

    function automatic logic [D*N-1:0] pu_f(input logic [D*N-1:0] a);
        logic [D*N-1:0] r;
        for (int i = 0; i < D; i++) r[i*N +: N] = N'(a[i*N +: N] + N'(i + 1));
        return r;
    endfunction

    function automatic logic [D*N-1:0] rnd_w();
        logic [D*N-1:0] r;
        for (int i = 0; i < D; i++) r[i*N +: N] = N'($urandom);
        return r;
    endfunction

    // Processing-unit model: result valid PU_LAT cycles after pu_start, junk otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            pu_st1[k] <= o_pu_start[k] ? pu_f(o_pu_a[k]) : rnd_w();
            pu_an[k]  <= pu_st1[k];
        end
    end

    int total = 0, bad = 0, cyc = 0;
    int sb = 0, ob = 0, n_loaded = 0, n_started = 0, n_captured = 0, n_drained = 0;
    int last_drain = -10;
    fr_t send_q[$];
    fr_t fr_log[$];
    int  load_cyc[$];
    int  start_cyc[$];

    task automatic chk(input string tag, input logic [D*N-1:0] obs, input logic [D*N-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rev(input int i);
        int r = 0;
        for (int b = 0; b < LG; b++) r = r * 2 + ((i >> b) & 1);
        return r;
    endfunction

    function automatic fr_t mk(input int a0, input int a1, input int a2, input int a3, input bit inv);
        fr_t f;
        f.inv = inv;
        f.a[0] = N'(a0); f.a[1] = N'(a1); f.a[2] = N'(a2); f.a[3] = N'(a3);
        return f;
    endfunction

    function automatic fr_t rnd_fr();
        fr_t f;
        f.inv = 1'($urandom);
        for (int i = 0; i < D; i++) f.a[i] = N'($urandom);
        return f;
    endfunction

    task automatic step(input int p_in, input int p_out);
        bit  iv, orr, exp_start, exp_ir, exp_ov;
        int  l;
        fr_t cur;
        @(negedge clk);
        cyc++;
        iv  = (send_q.size() != 0) && (int'($urandom_range(99)) < p_in);
        orr = int'($urandom_range(99)) < p_out;
        if0.in_valid  = iv;
        if0.in_data   = iv ? send_q[0].a[sb] : N'($urandom);
        if0.in_inv    = (iv && sb == 0) ? send_q[0].inv : 1'($urandom);
        if0.out_ready = orr;
        #1;
        exp_start = (n_loaded > n_started) && (n_started == n_drained) &&
                    (cyc >= load_cyc[n_started] + 2) && (cyc >= last_drain + 2);
        exp_ir = (n_loaded == n_captured);
        exp_ov = (n_captured > n_drained);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pu_start%0d", k), o_pu_start[k], exp_start);
            chk($sformatf("in_ready%0d", k), o_in_ready[k], exp_ir);
            chk($sformatf("out_valid%0d", k), o_out_valid[k], exp_ov);
            chk($sformatf("busy%0d", k), o_busy[k], (n_loaded > n_drained) || (sb != 0));
        end
        if (exp_start) begin
            n_started++;
            start_cyc.push_back(cyc);
        end
        if (n_started > n_captured) begin
            cur = fr_log[n_captured];
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pu_a%0d", k), o_pu_a[k], cur.a);
                chk($sformatf("pu_inv%0d", k), o_pu_inv[k], cur.inv);
            end
        end
        if (exp_ov) begin
            cur = fr_log[n_drained];
            for (int k = 0; k < 2; k++) begin
                l = (k == 1) ? rev(ob) : ob;
                chk($sformatf("out_data%0d", k), o_out_data[k], N'(cur.a[l] + l + 1));
                chk($sformatf("out_last%0d", k), o_out_last[k], ob == D - 1);
                chk($sformatf("out_inv%0d", k), o_out_inv[k], cur.inv);
            end
        end
        if (iv && exp_ir) begin
            sb++;
            if (sb == D) begin
                fr_log.push_back(send_q.pop_front());
                load_cyc.push_back(cyc);
                n_loaded++;
                sb = 0;
            end
        end
        if (orr && exp_ov) begin
            ob++;
            if (ob == D) begin
                ob = 0;
                n_drained++;
                last_drain = cyc;
            end
        end
        if (n_captured < n_started && cyc == start_cyc[n_captured] + PU_LAT) n_captured++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_in_ready%0d", k), o_in_ready[k], 1'b1);
            chk($sformatf("rst_out_valid%0d", k), o_out_valid[k], 1'b0);
            chk($sformatf("rst_out_last%0d", k), o_out_last[k], 1'b0);
            chk($sformatf("rst_out_inv%0d", k), o_out_inv[k], 1'b0);
            chk($sformatf("rst_pu_start%0d", k), o_pu_start[k], 1'b0);
            chk($sformatf("rst_pu_inv%0d", k), o_pu_inv[k], 1'b0);
            chk($sformatf("rst_busy%0d", k), o_busy[k], 1'b0);
            chk($sformatf("rst_pu_a%0d", k), o_pu_a[k], '0);
        end
        send_q.delete(); fr_log.delete(); load_cyc.delete(); start_cyc.delete();
        sb = 0; ob = 0; n_loaded = 0; n_started = 0; n_captured = 0; n_drained = 0;
        last_drain = -10;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int p_in, input int p_out, input int budget);
        int n = 0;
        while ((send_q.size() != 0 || sb != 0 || n_drained < n_loaded) && n < budget) begin
            step(p_in, p_out);
            n++;
        end
        chk("drain_done", n_drained, n_loaded + send_q.size());
    endtask

    initial begin
        int g;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.in_inv = 1'b0; if0.out_ready = 1'b0;
        do_reset();

        send_q.push_back(mk(10, 20, 30, 40, 0));
        drain(100, 100, 200);
        send_q.push_back(mk(1, 2, 3, 4, 0));
        drain(100, 100, 200);
        send_q.push_back(mk(17'h1ffff, 17'h1fffe, 17'h1fffd, 17'h1fffc, 1));
        drain(100, 100, 200);

        // Two frames back to back while the consumer stalls
        send_q.push_back(mk(100, 200, 300, 400, 0));
        send_q.push_back(mk(7, 9, 11, 13, 1));
        repeat (20) step(100, 0);
        drain(100, 100, 200);

        // Reset after two beats of a load, then a fresh frame
        send_q.push_back(mk(50, 51, 52, 53, 1));
        g = 0;
        while (sb < 2 && g < 50) begin step(100, 100); g++; end
        chk("midload_beats", sb, 2);
        do_reset();
        send_q.push_back(mk(5, 6, 7, 8, 0));
        drain(100, 100, 200);

        // Reset while the unit is running; nothing may be captured
        send_q.push_back(mk(60, 61, 62, 63, 1));
        g = 0;
        while (n_started == 0 && g < 50) begin step(100, 100); g++; end
        chk("run_started", n_started, 1);
        do_reset();
        repeat (10) step(100, 100);

        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 5; f++) send_q.push_back(rnd_fr());
            drain($urandom_range(100, 30), $urandom_range(100, 25), 3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
